// File: rtl/spi_reg_ctrl.sv
// Command decoder and byte-wide register bank sitting behind the 16-bit SPI slave.
// Each completed frame is decoded as a read/write and answered on data_trans for the next frame.
module spi_reg_ctrl #(
  parameter int          NREG   = 8,
  parameter logic [7:0]  DEV_ID = 8'hC3,
  parameter logic [7:0]  ACK_RD = 8'hA5,
  parameter logic [7:0]  ACK_WR = 8'h5A,
  parameter logic [7:0]  NAK    = 8'hEE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done,
  input  logic [15:0]       data_recv,
  output logic [15:0]       data_trans,
  output logic [8*NREG-1:0] reg_bus,
  output logic              wr_stb,
  output logic [6:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              err_flag,
  output logic              ovf_flag,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state;
  logic [15:0]         cmd_q;
  logic [7:0]          tag_q;
  logic [7:0]          byte_q;
  logic [8*NREG-1:8]   regs_q;

  logic                is_rd;
  logic [6:0]          addr;
  logic [7:0]          wdata;
  logic                in_bank;
  logic                is_ctl;
  logic [7:0]          rd_byte;

  // Register 0 is the constant device id; it has no storage behind it.
  assign reg_bus   = {regs_q, DEV_ID};
  assign fsm_state = state;

  assign is_rd   = cmd_q[15];
  assign addr    = cmd_q[14:8];
  assign wdata   = cmd_q[7:0];
  assign in_bank = ({25'd0, addr} < 32'(NREG));
  assign is_ctl  = (addr == 7'h7F);

  always_comb begin
    rd_byte = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (addr == 7'(k)) rd_byte = reg_bus[8*k +: 8];
    end
  end

  // Valid/ready: done is a one-cycle valid with no back-pressure; a done seen
  // outside IDLE cannot be accepted, is dropped and recorded in ovf_flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cmd_q      <= 16'h0000;
      tag_q      <= 8'h00;
      byte_q     <= 8'h00;
      regs_q     <= '0;
      data_trans <= 16'h0000;
      wr_stb     <= 1'b0;
      wr_addr    <= 7'd0;
      wr_data    <= 8'h00;
      err_flag   <= 1'b0;
      ovf_flag   <= 1'b0;
    end else begin
      wr_stb <= 1'b0;
      case (state)
        IDLE: begin
          if (done) begin
            cmd_q <= data_recv;
            state <= DECODE;
          end
        end
        DECODE: begin
          state <= RESP;
          if (!is_rd) begin
            if (in_bank && (addr != 7'd0)) begin
              for (int k = 1; k < NREG; k++) begin
                if (addr == 7'(k)) regs_q[8*k +: 8] <= wdata;
              end
              wr_stb  <= 1'b1;
              wr_addr <= addr;
              wr_data <= wdata;
              tag_q   <= ACK_WR;
              byte_q  <= wdata;
            end else if (is_ctl) begin
              err_flag <= 1'b0;
              ovf_flag <= 1'b0;
              tag_q    <= ACK_WR;
              byte_q   <= wdata;
            end else begin
              err_flag <= 1'b1;
              tag_q    <= NAK;
              byte_q   <= {1'b0, addr};
            end
          end else begin
            if (in_bank) begin
              tag_q  <= ACK_RD;
              byte_q <= rd_byte;
            end else if (is_ctl) begin
              tag_q  <= ACK_RD;
              byte_q <= {6'b0, ovf_flag, err_flag};
            end else begin
              err_flag <= 1'b1;
              tag_q    <= NAK;
              byte_q   <= {1'b0, addr};
            end
          end
        end
        RESP: begin
          data_trans <= {tag_q, byte_q};
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Placed last so an overrun set beats a same-edge flag clear.
      if (done && (state != IDLE)) ovf_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Bench for spi_reg_ctrl: timestamp-based reference model compared every cycle,
// directed scenarios pinned with literal values, then randomized frames.
module tb_spi_reg_ctrl;
  localparam int NREG = 8;

  logic              clk;
  logic              rst;
  logic              done;
  logic [15:0]       data_recv;
  logic [15:0]       data_trans;
  logic [8*NREG-1:0] reg_bus;
  logic              wr_stb;
  logic [6:0]        wr_addr;
  logic [7:0]        wr_data;
  logic              err_flag;
  logic              ovf_flag;
  logic [1:0]        fsm_state;

  int checks;
  int failures;

  spi_reg_ctrl #(.NREG(NREG)) dut (
    .clk(clk), .rst(rst), .done(done), .data_recv(data_recv),
    .data_trans(data_trans), .reg_bus(reg_bus), .wr_stb(wr_stb),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_flag(err_flag),
    .ovf_flag(ovf_flag), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: expectations for the current cycle plus pending events
  logic [7:0]  mbank [0:127];
  logic        m_err, m_ovf, m_stb;
  logic [6:0]  m_waddr;
  logic [7:0]  m_wdata;
  logic [15:0] m_dt;
  int          cyc;
  bit          acc_valid;
  int          acc_c;
  bit          have_cmd;
  int          cmd_c;
  logic [15:0] cmd;
  bit          have_resp;
  int          resp_c;
  logic [15:0] resp_word;

  task automatic model_reset();
    for (int k = 0; k < 128; k++) mbank[k] = 8'h00;
    mbank[0] = 8'hC3;
    m_err = 0; m_ovf = 0; m_stb = 0; m_waddr = 0; m_wdata = 0; m_dt = 16'h0000;
    acc_valid = 0; have_cmd = 0; have_resp = 0;
  endtask

  function automatic logic [8*NREG-1:0] model_bus();
    logic [8*NREG-1:0] b;
    for (int k = 0; k < NREG; k++) b[8*k +: 8] = mbank[k];
    return b;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // One clock cycle: compare outputs against the model, drive inputs, advance the model.
  task automatic step(input bit d, input logic [15:0] dat);
    logic        n_err, n_ovf, n_stb;
    logic [15:0] n_dt;
    logic [6:0]  a;
    logic [7:0]  wd;
    @(negedge clk);
    chk("data_trans", 64'(data_trans), 64'(m_dt));
    chk("wr_stb", 64'(wr_stb), 64'(m_stb));
    if (m_stb) begin
      chk("wr_addr", 64'(wr_addr), 64'(m_waddr));
      chk("wr_data", 64'(wr_data), 64'(m_wdata));
    end
    chk("reg_bus", 64'(reg_bus), 64'(model_bus()));
    chk("err_flag", 64'(err_flag), 64'(m_err));
    chk("ovf_flag", 64'(ovf_flag), 64'(m_ovf));
    done = d;
    data_recv = dat;
    n_err = m_err; n_ovf = m_ovf; n_stb = 0; n_dt = m_dt;
    if (have_resp && resp_c == cyc) begin
      n_dt = resp_word;
      have_resp = 0;
    end
    if (have_cmd && cmd_c == cyc) begin
      a = cmd[14:8];
      wd = cmd[7:0];
      if (!cmd[15]) begin
        if (a >= 1 && int'(a) < NREG) begin
          mbank[a] = wd; n_stb = 1; m_waddr = a; m_wdata = wd;
          resp_word = {8'h5A, wd};
        end else if (a == 7'h7F) begin
          n_err = 0; n_ovf = 0; resp_word = {8'h5A, wd};
        end else begin
          n_err = 1; resp_word = {8'hEE, 1'b0, a};
        end
      end else begin
        if (int'(a) < NREG) resp_word = {8'hA5, mbank[a]};
        else if (a == 7'h7F) resp_word = {8'hA5, 6'b0, m_ovf, m_err};
        else begin
          n_err = 1; resp_word = {8'hEE, 1'b0, a};
        end
      end
      have_resp = 1; resp_c = cyc + 1; have_cmd = 0;
    end
    if (d) begin
      if (acc_valid && cyc >= acc_c + 1 && cyc <= acc_c + 2) n_ovf = 1;
      else begin
        acc_valid = 1; acc_c = cyc; have_cmd = 1; cmd_c = cyc + 1; cmd = dat;
      end
    end
    m_err = n_err; m_ovf = n_ovf; m_stb = n_stb; m_dt = n_dt;
    cyc++;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 0; done = 0; data_recv = 16'h0000;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Frame followed by three idle cycles; literal wr_stb at T+2 and data_trans at T+3.
  task automatic frame_lit(input logic [15:0] f, input logic exp_stb, input logic [15:0] exp_dt);
    step(1, f);
    step(0, 16'h0000);
    step(0, 16'h0000);
    chk("lit_wr_stb", 64'(wr_stb), 64'(exp_stb));
    step(0, 16'h0000);
    chk("lit_data_trans", 64'(data_trans), 64'(exp_dt));
  endtask

  function automatic logic [15:0] rand_frame();
    logic [6:0] a;
    case ($urandom_range(0, 3))
      0, 1: a = 7'($urandom_range(0, 9));
      2: a = 7'h7F;
      default: a = 7'($urandom_range(0, 127));
    endcase
    return {1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255))};
  endfunction

  initial begin
    checks = 0; failures = 0; cyc = 0;
    rst = 0; done = 0; data_recv = 16'h0000;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1;

    // reset state
    step(0, 16'h0000);
    chk("rst_data_trans", 64'(data_trans), 64'h0000);
    chk("rst_reg_bus", 64'(reg_bus), 64'h00000000_000000C3);
    chk("rst_flags", 64'({err_flag, ovf_flag, wr_stb}), 64'h0);

    // write, reads, rejected commands
    frame_lit(16'h0337, 1'b1, 16'h5A37);
    chk("lit_wr_addr", 64'(wr_addr), 64'd3);
    chk("lit_wr_data", 64'(wr_data), 64'h37);
    frame_lit(16'h8300, 1'b0, 16'hA537);
    frame_lit(16'h8000, 1'b0, 16'hA5C3);
    frame_lit(16'h0012, 1'b0, 16'hEE00);
    frame_lit(16'h8900, 1'b0, 16'hEE09);
    chk("lit_err_flag", 64'(err_flag), 64'h1);
    chk("lit_bank_kept", 64'(reg_bus), 64'h00000000_370000C3);
    frame_lit(16'hFF00, 1'b0, 16'hA501);

    // overrun: second done in the DECODE cycle is dropped
    step(1, 16'h0455);
    step(1, 16'h0611);
    step(0, 16'h0000);
    step(0, 16'h0000);
    chk("ovr_data_trans", 64'(data_trans), 64'h5A55);
    chk("ovr_ovf_flag", 64'(ovf_flag), 64'h1);
    chk("ovr_bank", 64'(reg_bus), 64'h00000055_370000C3);
    frame_lit(16'h7F00, 1'b0, 16'h5A00);
    chk("clr_flags", 64'({err_flag, ovf_flag}), 64'h0);

    // reset in the DECODE cycle aborts the write
    step(1, 16'h0566);
    apply_reset();
    step(0, 16'h0000);
    chk("abort_state", 64'(fsm_state), 64'h0);
    chk("abort_bank", 64'(reg_bus), 64'h00000000_000000C3);
    chk("abort_data_trans", 64'(data_trans), 64'h0000);
    repeat (4) step(0, 16'h0000);

    // randomized frames with random spacing, including back-to-back overruns
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) step(1, rand_frame());
      else step(0, 16'($urandom_range(0, 65535)));
    end
    repeat (4) step(0, 16'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
